// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/mem/wb
// and drives ALU control code, mux selects and datapath strobes.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   opcode, funct, zero   instruction fields and ALU zero flag
//   alu_control           ALU op (0010 add, 0110 sub, 0111 slt, 0000 zero)
//   alu_src_a/b, iord     datapath mux selects
//   mem_read/mem_write    memory strobes
//   ir_write, reg_write   register load strobes
//   reg_dst, mem_to_reg   register-file write muxes
//   pc_source, pc_en      PC update control (pc_en Mealy in BRANCH)
//   state                 current state, for debug
module mips_mc_control #(
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ZERO = 4'b0000;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = NOP_ON_ILLEGAL ? S_FETCH
                                                           : S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXEC:    state_d = S_RWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ILLEGAL: state_d = S_ILLEGAL;
            // MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB and unused codes
            default:   state_d = S_FETCH;
        endcase
    end

    // Strobes before reset gating
    logic mem_read_s, mem_write_s, ir_write_s, reg_write_s, pc_en_s;

    always_comb begin
        alu_control = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        iord        = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write_s = 1'b0;
        pc_source   = 2'b00;
        pc_en_s     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s = 1'b1;
                ir_write_s = 1'b1;
                alu_src_b  = 2'b01;
                pc_en_s    = 1'b1;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord       = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord        = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100000: alu_control = ALU_ADD;
                    6'b100010: alu_control = ALU_SUB;
                    6'b101010: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ZERO;
                endcase
            end
            S_RWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_source   = 2'b01;
                pc_en_s     = zero;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en_s   = 1'b1;
            end
            S_ADDIWB: reg_write_s = 1'b1;
            default: ;
        endcase
    end

    // Strobes are held low for as long as reset is asserted
    assign mem_read  = mem_read_s  & rst_n;
    assign mem_write = mem_write_s & rst_n;
    assign ir_write  = ir_write_s  & rst_n;
    assign reg_write = reg_write_s & rst_n;
    assign pc_en     = pc_en_s     & rst_n;
    assign state     = state_q;

endmodule
